// File: rtl/adder_host.sv
// adder_host: command and result FIFOs wrapped around a bf16 adder with one operation in flight.
// Define ADDER_HOST_ACCUM_EN to add cmd_accum and an accumulator that can replace operand b.
module adder_host #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
`ifdef ADDER_HOST_ACCUM_EN
    input  logic        cmd_accum,
`endif
    input  logic        cmd_valid,
    output logic        cmd_ready,
    output logic [15:0] res_data,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] adder_input_a,
    output logic [15:0] adder_input_b,
    output logic        adder_input_STB,
    input  logic        adder_BUSY,
    input  logic [15:0] adder_output_sum,
    input  logic        adder_output_STB,
    output logic        output_module_BUSY
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    state_e        r_state;
    logic [15:0]   r_opA;
    logic [15:0]   r_opB;
    logic          r_stb;

    logic [15:0]   r_cmdMemA [DEPTH];
    logic [15:0]   r_cmdMemB [DEPTH];
    logic [AW-1:0] r_cmdWrPtr;
    logic [AW-1:0] r_cmdRdPtr;
    logic [AW:0]   r_cmdCount;

    logic [15:0]   r_resMem [DEPTH];
    logic [AW-1:0] r_resWrPtr;
    logic [AW-1:0] r_resRdPtr;
    logic [AW:0]   r_resCount;

    logic          w_cmdPush;
    logic          w_cmdPop;
    logic          w_cmdEmpty;
    logic          w_resPush;
    logic          w_resPop;
    logic          w_resFull;
    logic [15:0]   w_headB;

    assign w_cmdEmpty = (r_cmdCount == '0);
    assign w_resFull  = (r_resCount == FULL_CNT);

    assign cmd_ready = (r_cmdCount != FULL_CNT);
    assign res_valid = (r_resCount != '0);
    assign res_data  = r_resMem[r_resRdPtr];

    assign w_cmdPush = cmd_valid && cmd_ready;
    assign w_cmdPop  = (r_state == IDLE) && !w_cmdEmpty;
    assign w_resPop  = res_valid && res_ready;

    // Capture is gated by the full flag only; a pop on the same edge frees space for the next edge.
    assign output_module_BUSY = (r_state != WAIT) || w_resFull;
    assign w_resPush = (r_state == WAIT) && adder_output_STB && !w_resFull;

    assign adder_input_a   = r_opA;
    assign adder_input_b   = r_opB;
    assign adder_input_STB = r_stb;

`ifdef ADDER_HOST_ACCUM_EN
    logic          r_cmdMemAcc [DEPTH];
    logic [15:0]   r_accum;

    assign w_headB = r_cmdMemAcc[r_cmdRdPtr] ? r_accum : r_cmdMemB[r_cmdRdPtr];

    always_ff @(posedge clk) begin
        if (w_cmdPush) begin
            r_cmdMemAcc[r_cmdWrPtr] <= cmd_accum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_accum <= 16'h0000;
        end else if (w_resPush) begin
            r_accum <= adder_output_sum;
        end
    end
`else
    assign w_headB = r_cmdMemB[r_cmdRdPtr];
`endif

    always_ff @(posedge clk) begin
        if (w_cmdPush) begin
            r_cmdMemA[r_cmdWrPtr] <= cmd_a;
            r_cmdMemB[r_cmdWrPtr] <= cmd_b;
        end
        if (w_resPush) begin
            r_resMem[r_resWrPtr] <= adder_output_sum;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmdWrPtr <= '0;
            r_cmdRdPtr <= '0;
            r_cmdCount <= '0;
            r_resWrPtr <= '0;
            r_resRdPtr <= '0;
            r_resCount <= '0;
        end else begin
            if (w_cmdPush) r_cmdWrPtr <= r_cmdWrPtr + AW'(1);
            if (w_cmdPop)  r_cmdRdPtr <= r_cmdRdPtr + AW'(1);
            case ({w_cmdPush, w_cmdPop})
                2'b10:   r_cmdCount <= r_cmdCount + (AW + 1)'(1);
                2'b01:   r_cmdCount <= r_cmdCount - (AW + 1)'(1);
                default: r_cmdCount <= r_cmdCount;
            endcase

            if (w_resPush) r_resWrPtr <= r_resWrPtr + AW'(1);
            if (w_resPop)  r_resRdPtr <= r_resRdPtr + AW'(1);
            case ({w_resPush, w_resPop})
                2'b10:   r_resCount <= r_resCount + (AW + 1)'(1);
                2'b01:   r_resCount <= r_resCount - (AW + 1)'(1);
                default: r_resCount <= r_resCount;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_opA   <= 16'h0000;
            r_opB   <= 16'h0000;
            r_stb   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_cmdEmpty) begin
                        r_opA   <= r_cmdMemA[r_cmdRdPtr];
                        r_opB   <= w_headB;
                        r_stb   <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!adder_BUSY) begin
                        r_stb   <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_resPush) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_stb   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_host.sv
// Self-checking bench for adder_host: behavioural bf16 adder model plus a spec-level scoreboard.
// Define ADDER_HOST_ACCUM_EN for both files to exercise the accumulator feature.
module tb_adder_host;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cmd_a;
   logic [15:0] cmd_b;
`ifdef ADDER_HOST_ACCUM_EN
   logic        cmd_accum;
`endif
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] adder_input_a;
   logic [15:0] adder_input_b;
   logic        adder_input_STB;
   logic        adder_BUSY;
   logic [15:0] adder_output_sum;
   logic        adder_output_STB;
   logic        output_module_BUSY;

   int testsRun = 0;
   int testsFailed = 0;

   int  modelLatency = 3;
   bit  modelRandLat = 0;
   bit  modelRandHold = 0;
   int  xferCount = 0;
   int  captCount = 0;

   logic [15:0] expA[$];
   logic [15:0] expB[$];
   logic [15:0] expRes[$];
   logic [15:0] accModel = 16'h0000;
   logic [15:0] lastRes = 16'h0000;

   adder_host #(.DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cmd_a              (cmd_a),
      .cmd_b              (cmd_b),
`ifdef ADDER_HOST_ACCUM_EN
      .cmd_accum          (cmd_accum),
`endif
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .res_data           (res_data),
      .res_valid          (res_valid),
      .res_ready          (res_ready),
      .adder_input_a      (adder_input_a),
      .adder_input_b      (adder_input_b),
      .adder_input_STB    (adder_input_STB),
      .adder_BUSY         (adder_BUSY),
      .adder_output_sum   (adder_output_sum),
      .adder_output_STB   (adder_output_STB),
      .output_module_BUSY (output_module_BUSY)
   );

   always #5 clk = ~clk;

   // bf16 values are widened to doubles, added exactly, then rounded to nearest-even bf16.
   function automatic real bfToReal(input logic [15:0] x);
      logic [63:0] bits;
      if (x[14:7] == 8'd0) return 0.0;
      bits = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
      return $bitstoreal(bits);
   endfunction

   function automatic logic [15:0] realToBf(input real r);
      logic [63:0] bits;
      logic [10:0] e;
      logic [14:0] mag;
      if (r == 0.0) return 16'h0000;
      bits = $realtobits(r);
      e = bits[62:52] - 11'd896;
      mag = {e[7:0], bits[51:45]};
      if (bits[44] && ((|bits[43:0]) || bits[45])) mag = mag + 15'd1;
      return {bits[63], mag};
   endfunction

   function automatic logic [15:0] bf16Add(input logic [15:0] a, input logic [15:0] b);
      return realToBf(bfToReal(a) + bfToReal(b));
   endfunction

   function automatic logic [15:0] randBf();
      logic [7:0] e;
      e = 8'($urandom_range(134, 120));
      return {1'($urandom_range(1, 0)), e, 7'($urandom_range(127, 0))};
   endfunction

   // Adder model: samples handshakes on the rising edge, drives its outputs 1 time unit later.
   initial begin
      bit          xfer;
      bit          capt;
      bit          pending;
      bit          holdPhase;
      int          remaining;
      logic [15:0] sa;
      logic [15:0] sb;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [15:0] pendSum;
      pending = 0;
      holdPhase = 0;
      remaining = 0;
      pendSum = 16'h0000;
      adder_output_STB = 1'b0;
      adder_output_sum = 16'h0000;
      forever begin
         @(posedge clk);
         xfer = rst_n && adder_input_STB && !adder_BUSY;
         capt = rst_n && adder_output_STB && !output_module_BUSY && !holdPhase;
         sa = adder_input_a;
         sb = adder_input_b;
         #1;
         if (!rst_n) begin
            pending = 0;
            holdPhase = 0;
            adder_output_STB = 1'b0;
         end else begin
            if (capt) begin
               captCount++;
               pending = 0;
               if (modelRandHold && $urandom_range(1, 0) == 1) holdPhase = 1;
               else adder_output_STB = 1'b0;
            end else if (holdPhase) begin
               holdPhase = 0;
               adder_output_STB = 1'b0;
            end
            if (pending && !adder_output_STB) begin
               if (remaining > 0) remaining--;
               if (remaining == 0) begin
                  adder_output_sum = pendSum;
                  adder_output_STB = 1'b1;
               end
            end
            if (xfer) begin
               testsRun++;
               if (expA.size() == 0) begin
                  testsFailed++;
                  $display("[TB] FAIL xfer_unexpected: got a=%h b=%h want no transfer", sa, sb);
               end else begin
                  ea = expA.pop_front();
                  eb = expB.pop_front();
                  if ({sa, sb} !== {ea, eb}) begin
                     testsFailed++;
                     $display("[TB] FAIL xfer_operands: got a=%h b=%h want a=%h b=%h", sa, sb, ea, eb);
                  end
               end
               testsRun++;
               if (pending) begin
                  testsFailed++;
                  $display("[TB] FAIL one_outstanding: got second transfer want none while busy");
               end
               xferCount++;
               pending = 1;
               pendSum = bf16Add(sa, sb);
               remaining = modelRandLat ? int'($urandom_range(5, 0)) : modelLatency;
               if (remaining == 0) begin
                  adder_output_sum = pendSum;
                  adder_output_STB = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Leaves cmd_valid high so consecutive calls push back to back; stopPush ends the burst.
   task automatic pushCmd(input logic [15:0] a, input logic [15:0] b, input bit acc);
      int guard = 0;
      logic [15:0] opB;
      logic [15:0] res;
      @(negedge clk);
      cmd_a = a;
      cmd_b = b;
      cmd_valid = 1'b1;
`ifdef ADDER_HOST_ACCUM_EN
      cmd_accum = acc;
`endif
      while (!cmd_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (!cmd_ready) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL push_timeout: got cmd_ready=0 want 1");
         cmd_valid = 1'b0;
         return;
      end
      opB = acc ? accModel : b;
      res = bf16Add(a, opB);
      expA.push_back(a);
      expB.push_back(opB);
      expRes.push_back(res);
      accModel = res;
   endtask

   task automatic stopPush();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int n, input bit stall);
      int got = 0;
      int cyc = 0;
      logic [15:0] e;
      while (got < n && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         res_ready = 1'b0;
         if (res_valid && !(stall && $urandom_range(2, 0) == 0)) begin
            testsRun++;
            if (expRes.size() == 0) begin
               testsFailed++;
               $display("[TB] FAIL res_unexpected: got %h want no result", res_data);
            end else begin
               e = expRes.pop_front();
               if (res_data !== e) begin
                  testsFailed++;
                  $display("[TB] FAIL res_data: got %h want %h", res_data, e);
               end
            end
            lastRes = res_data;
            res_ready = 1'b1;
            got++;
         end
      end
      @(negedge clk);
      res_ready = 1'b0;
      if (got < n) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain_timeout: got %0d results want %0d", got, n);
      end
   endtask

   task automatic pulseReset();
      @(negedge clk);
      rst_n = 1'b0;
      expA.delete();
      expB.delete();
      expRes.delete();
      accModel = 16'h0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_a = 16'h0000;
      cmd_b = 16'h0000;
`ifdef ADDER_HOST_ACCUM_EN
      cmd_accum = 1'b0;
`endif
      cmd_valid = 1'b0;
      res_ready = 1'b0;
      adder_BUSY = 1'b0;
      repeat (3) @(negedge clk);
      testsRun += 6;
      if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
      if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_res_valid: got %b want 0", res_valid); end
      if (adder_input_STB !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_stb: got %b want 0", adder_input_STB); end
      if (adder_input_a !== 16'h0000) begin testsFailed++; $display("[TB] FAIL rst_a: got %h want 0000", adder_input_a); end
      if (adder_input_b !== 16'h0000) begin testsFailed++; $display("[TB] FAIL rst_b: got %h want 0000", adder_input_b); end
      if (output_module_BUSY !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_out_busy: got %b want 1", output_module_BUSY); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int cyc = 0;
      modelLatency = 10;
      pushCmd(16'h3F80, 16'h4000, 1'b0);
      stopPush();
      testsRun++;
      if (adder_input_STB !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_stb_early: got %b want 0", adder_input_STB); end
      @(negedge clk);
      testsRun += 3;
      if (adder_input_STB !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_stb_latency: got %b want 1", adder_input_STB); end
      if (adder_input_a !== 16'h3F80) begin testsFailed++; $display("[TB] FAIL basic_a: got %h want 3f80", adder_input_a); end
      if (adder_input_b !== 16'h4000) begin testsFailed++; $display("[TB] FAIL basic_b: got %h want 4000", adder_input_b); end
      while (!(adder_output_STB && !output_module_BUSY) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      testsRun += 2;
      if (cyc >= 100) begin testsFailed++; $display("[TB] FAIL basic_capture_timeout: got no capture window want one"); end
      if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_res_early: got %b want 0", res_valid); end
      @(negedge clk);
      testsRun++;
      if (res_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_res_latency: got %b want 1", res_valid); end
      drain(1, 1'b0);
      testsRun += 2;
      if (lastRes !== 16'h4040) begin testsFailed++; $display("[TB] FAIL basic_sum: got %h want 4040", lastRes); end
      if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_after_pop: got %b want 0", res_valid); end
   endtask

   task automatic test_zero();
      modelLatency = 2;
      pushCmd(16'h3F80, 16'hBF80, 1'b0);
      stopPush();
      drain(1, 1'b0);
      testsRun++;
      if (lastRes !== 16'h0000) begin testsFailed++; $display("[TB] FAIL zero_sum: got %h want 0000", lastRes); end
   endtask

   task automatic test_busy();
      int cyc = 0;
      int x0;
      logic [15:0] a0;
      logic [15:0] b0;
      modelLatency = 1;
      adder_BUSY = 1'b1;
      pushCmd(16'h4000, 16'h4000, 1'b0);
      stopPush();
      while (!adder_input_STB && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      a0 = adder_input_a;
      b0 = adder_input_b;
      x0 = xferCount;
      testsRun++;
      if (adder_input_STB !== 1'b1) begin testsFailed++; $display("[TB] FAIL busy_stb_rise: got %b want 1", adder_input_STB); end
      repeat (2) begin
         @(negedge clk);
         testsRun++;
         if (adder_input_STB !== 1'b1 || adder_input_a !== a0 || adder_input_b !== b0) begin
            testsFailed++;
            $display("[TB] FAIL busy_hold: got stb=%b a=%h b=%h want stb=1 a=%h b=%h", adder_input_STB, adder_input_a, adder_input_b, a0, b0);
         end
      end
      testsRun++;
      if (xferCount !== x0) begin testsFailed++; $display("[TB] FAIL busy_no_xfer: got %0d transfers want %0d", xferCount, x0); end
      adder_BUSY = 1'b0;
      @(negedge clk);
      testsRun += 2;
      if (adder_input_STB !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_stb_clear: got %b want 0", adder_input_STB); end
      if (xferCount !== x0 + 1) begin testsFailed++; $display("[TB] FAIL busy_one_xfer: got %0d transfers want %0d", xferCount, x0 + 1); end
      drain(1, 1'b0);
      testsRun += 2;
      if (lastRes !== 16'h4080) begin testsFailed++; $display("[TB] FAIL busy_sum: got %h want 4080", lastRes); end
      if (xferCount !== x0 + 1) begin testsFailed++; $display("[TB] FAIL busy_total_xfer: got %0d want %0d", xferCount, x0 + 1); end
   endtask

   task automatic test_full();
      int c0 = captCount;
      int cyc = 0;
      logic [15:0] e;
      modelLatency = 2;
      res_ready = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         pushCmd(16'h3F80, 16'h3F80, 1'b0);
         stopPush();
      end
      while (!(captCount - c0 == DEPTH && adder_output_STB) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      repeat (3) @(negedge clk);
      testsRun += 4;
      if (captCount - c0 !== DEPTH) begin testsFailed++; $display("[TB] FAIL full_stored: got %0d want %0d", captCount - c0, DEPTH); end
      if (output_module_BUSY !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_busy: got %b want 1", output_module_BUSY); end
      if (adder_output_STB !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_fifth_held: got %b want 1", adder_output_STB); end
      if (res_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_res_valid: got %b want 1", res_valid); end
      testsRun++;
      e = expRes.pop_front();
      if (res_data !== e) begin testsFailed++; $display("[TB] FAIL full_pop_data: got %h want %h", res_data, e); end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      testsRun += 2;
      if (captCount - c0 !== DEPTH) begin testsFailed++; $display("[TB] FAIL full_no_capture_on_pop: got %0d want %0d", captCount - c0, DEPTH); end
      if (output_module_BUSY !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_busy_release: got %b want 0", output_module_BUSY); end
      @(negedge clk);
      testsRun++;
      if (captCount - c0 !== DEPTH + 1) begin testsFailed++; $display("[TB] FAIL full_fifth_capture: got %0d want %0d", captCount - c0, DEPTH + 1); end
      drain(DEPTH, 1'b0);
      testsRun++;
      if (lastRes !== 16'h4000) begin testsFailed++; $display("[TB] FAIL full_sum: got %h want 4000", lastRes); end
   endtask

   task automatic test_back_to_back();
      int n = 40;
      int c0 = captCount;
      bit done = 0;
      modelRandLat = 1;
      modelRandHold = 1;
      fork
         begin
            fork
               begin
                  for (int i = 0; i < n; i++) begin
                     bit acc = 0;
`ifdef ADDER_HOST_ACCUM_EN
                     acc = 1'($urandom_range(1, 0));
`endif
                     pushCmd(randBf(), randBf(), acc);
                     if ($urandom_range(3, 0) == 0) stopPush();
                  end
                  stopPush();
               end
               drain(n, 1'b1);
            join
            done = 1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               adder_BUSY = ($urandom_range(3, 0) == 0);
            end
            adder_BUSY = 1'b0;
         end
      join
      modelRandLat = 0;
      modelRandHold = 0;
      repeat (3) @(negedge clk);
      testsRun += 2;
      if (captCount - c0 !== n) begin testsFailed++; $display("[TB] FAIL b2b_captures: got %0d want %0d", captCount - c0, n); end
      if (expRes.size() !== 0) begin testsFailed++; $display("[TB] FAIL b2b_leftover: got %0d pending want 0", expRes.size()); end
   endtask

   task automatic test_reset_wait();
      int cyc = 0;
      int x0 = xferCount;
      int c0;
      modelLatency = 20;
      pushCmd(16'h4000, 16'h3F80, 1'b0);
      stopPush();
      while (xferCount == x0 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      testsRun++;
      if (output_module_BUSY !== 1'b0) begin testsFailed++; $display("[TB] FAIL rw_in_wait: got busy=%b want 0", output_module_BUSY); end
      c0 = captCount;
      rst_n = 1'b0;
      expA.delete();
      expB.delete();
      expRes.delete();
      accModel = 16'h0000;
      @(negedge clk);
      testsRun += 4;
      if (adder_input_STB !== 1'b0) begin testsFailed++; $display("[TB] FAIL rw_stb: got %b want 0", adder_input_STB); end
      if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rw_res_valid: got %b want 0", res_valid); end
      if (cmd_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rw_cmd_ready: got %b want 1", cmd_ready); end
      if (output_module_BUSY !== 1'b1) begin testsFailed++; $display("[TB] FAIL rw_out_busy: got %b want 1", output_module_BUSY); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      testsRun += 2;
      if (res_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rw_no_result: got %b want 0", res_valid); end
      if (captCount !== c0) begin testsFailed++; $display("[TB] FAIL rw_no_capture: got %0d want %0d", captCount, c0); end
      modelLatency = 3;
      pushCmd(16'h3F80, 16'h4000, 1'b0);
      stopPush();
      drain(1, 1'b0);
      testsRun++;
      if (lastRes !== 16'h4040) begin testsFailed++; $display("[TB] FAIL rw_recover: got %h want 4040", lastRes); end
   endtask

`ifdef ADDER_HOST_ACCUM_EN
   task automatic test_accum();
      logic [15:0] want [3];
      want[0] = 16'h3F80;
      want[1] = 16'h4000;
      want[2] = 16'h4040;
      modelLatency = 2;
      pulseReset();
      for (int i = 0; i < 3; i++) begin
         pushCmd(16'h3F80, 16'h1234, 1'b1);
         stopPush();
         drain(1, 1'b0);
         testsRun++;
         if (lastRes !== want[i]) begin testsFailed++; $display("[TB] FAIL accum_%0d: got %h want %h", i, lastRes, want[i]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_busy();
      test_full();
      test_back_to_back();
      test_reset_wait();
`ifdef ADDER_HOST_ACCUM_EN
      test_accum();
`endif
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/adder_host.md
ADDER_HOST -- requirements
Module: adder_host

Interface
REQ-001 Parameter DEPTH, default 4, meaning entries in each of the command FIFO and the result FIFO (power of two, at least 2).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 cmd_a, cmd_b  input  16 each  bf16 operands of one command.
REQ-005 cmd_valid  input  1  command present; cmd_ready  output  1  command FIFO not full.
REQ-006 res_data  output  16  head of result FIFO; res_valid  output  1  result FIFO not empty; res_ready  input  1  consumer pops head.
REQ-007 adder_input_a, adder_input_b  output  16 each  operands driven to the adder.
REQ-008 adder_input_STB  output  1  operands valid; adder_BUSY  input  1  adder not accepting.
REQ-009 adder_output_sum  input  16  adder result; adder_output_STB  input  1  result valid; output_module_BUSY  output  1  host not accepting result.

Function
REQ-010 Command push SHALL occur on an edge with cmd_valid=1 and cmd_ready=1; result pop SHALL occur on an edge with res_valid=1 and res_ready=1.
REQ-011 Push and pop on the same edge SHALL both take effect in each FIFO; pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-012 FSM states: IDLE, ISSUE, WAIT; exactly one operation outstanding at the adder.
REQ-013 IDLE: when command FIFO is non-empty, latch head into adder_input_a/b, pop it, go to ISSUE on the same edge.
REQ-014 ISSUE: adder_input_STB=1 with operands held stable; transfer SHALL be the edge where adder_input_STB=1 and adder_BUSY=0; on that edge adder_input_STB clears and state goes to WAIT.
REQ-015 adder_BUSY=1 in ISSUE SHALL hold the state with STB and operands unchanged, for any number of cycles.
REQ-016 output_module_BUSY SHALL be 1 in IDLE and ISSUE and SHALL equal the result-FIFO-full flag in WAIT.
REQ-017 WAIT: capture SHALL be the edge where adder_output_STB=1 and output_module_BUSY=0; adder_output_sum is pushed into the result FIFO and state returns to IDLE.
REQ-018 Exactly one result SHALL be pushed per command; the adder holding adder_output_STB high after capture SHALL not cause a second push, because output_module_BUSY is 1 outside WAIT.
REQ-019 A result-FIFO pop on the capture edge while full SHALL not permit a push that edge; capture occurs on the next edge.
REQ-020 Minimum host overhead: command push to adder_input_STB high = 2 edges; capture to res_valid high = 1 edge.
REQ-021 Results SHALL leave in command order; res_data SHALL be bit-exact adder_output_sum.

Reset
REQ-022 On rst_n low, state=IDLE, FIFOs empty, adder_input_STB=0, adder_input_a/b=0, output_module_BUSY=1, res_valid=0, cmd_ready=1 (FIFO contents don't-care).
REQ-023 Reset in ISSUE or WAIT SHALL abandon the operation with no result pushed; the adder SHALL be reset in the same window (system rule).

Configuration
REQ-024 Macro ADDER_HOST_ACCUM_EN: when defined, port cmd_accum (input, 1) is added and stored per FIFO entry; a 16-bit accumulator register (reset 0x0000) is loaded with every captured result.
REQ-025 With ADDER_HOST_ACCUM_EN defined and cmd_accum=1, IDLE SHALL drive adder_input_b from the accumulator instead of cmd_b; cmd_accum=0 behaves as the macro-absent case.
REQ-026 Without ADDER_HOST_ACCUM_EN, neither the port nor the register exists, and operands always come from cmd_a/cmd_b.

Verification
REQ-027 cmd 0x3F80+0x4000, adder model with 10-cycle latency -> res_data 0x4040, one pop, res_valid then 0.
REQ-028 cmd 0x3F80+0xBF80 -> res_data 0x0000 (positive zero).
REQ-029 adder_BUSY forced 1 for 3 cycles during ISSUE -> STB and operands stable for 3 cycles, exactly one transfer on the first edge with adder_BUSY=0.
REQ-030 DEPTH=4, res_ready=0, 5 commands of 0x3F80+0x3F80 -> 4 results 0x4000 stored; output_module_BUSY=1 while adder holds the 5th; one pop -> 5th captured the following edge.
REQ-031 ADDER_HOST_ACCUM_EN, three cmds a=0x3F80 with cmd_accum=1 -> results 0x3F80, 0x4000, 0x4040.
REQ-032 rst_n pulsed low in WAIT -> STB=0, FIFOs empty, no result pushed; next command completes normally.
